// File: rtl/data_path.sv
// Single-bus 32-bit datapath for the teaching RISC CPU: register set, one-hot bus mux and
// combinational ALU. The strobes are sequenced from outside, so there is no FSM here.
module data_path #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             PCout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R0out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic [4:0]       opcode,
    input  logic             R0in,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighIn,
    input  logic             ZLowIn,
    input  logic             Cin,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] IRq,
    output logic [WIDTH-1:0] MARq
);

    localparam int unsigned ZW   = 2 * WIDTH;
    localparam int unsigned SW   = $clog2(WIDTH);
    localparam int unsigned NREG = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [ZW-1:0]    z_q, z_d;
    logic [NREG-1:0]  r_in;

    logic [WIDTH-1:0] bus;
    logic [ZW-1:0]    alu;

    logic [SW-1:0]           sh;
    logic [ZW-1:0]           dbl, rol_full, ax, bx, prod_w;
    logic [WIDTH-1:0]        ror_w, shra_w, sum_w, diff_w, neg_w, not_w, and_w, or_w;
    logic [WIDTH-1:0]        div_quo, div_rem;
    logic signed [WIDTH-1:0] sa, sb;
    logic                    unused_ok;

    assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    // Shared bus: fixed-priority mux, zero when idle
    always_comb begin
        bus = '0;
        if      (Zlowout)  bus = z_q[WIDTH-1:0];
        else if (Zhighout) bus = z_q[ZW-1:WIDTH];
        else if (MDRout)   bus = mdr_q;
        else if (PCout)    bus = pc_q;
        else if (R0out)    bus = rf_q[0];
        else if (R2out)    bus = rf_q[2];
        else if (R3out)    bus = rf_q[3];
        else if (R4out)    bus = rf_q[4];
        else if (R5out)    bus = rf_q[5];
        else if (R6out)    bus = rf_q[6];
        else if (R7out)    bus = rf_q[7];
    end

    assign sh       = y_q[SW-1:0];
    assign dbl      = {bus, bus};
    assign ror_w    = WIDTH'(dbl >> sh);
    assign rol_full = dbl << sh;
    assign shra_w   = $signed(bus) >>> sh;
    assign sum_w    = y_q + bus + WIDTH'(Cin);
    assign diff_w   = y_q - bus - WIDTH'(Cin);
    assign neg_w    = '0 - bus;
    assign not_w    = ~bus;
    assign and_w    = y_q & bus;
    assign or_w     = y_q | bus;
    assign ax       = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    assign bx       = {{WIDTH{bus[WIDTH-1]}}, bus};
    assign prod_w   = ax * bx;
    assign sa       = $signed(y_q);
    assign sb       = $signed(bus);

    // Signed divide with defined results for divide-by-zero and the MIN/-1 overflow
    always_comb begin
        div_quo = '1;
        div_rem = y_q;
        if (bus == '0) begin
            div_quo = '1;
            div_rem = y_q;
        end else if (y_q == SMIN && bus == '1) begin
            div_quo = SMIN;
            div_rem = '0;
        end else begin
            div_quo = sa / sb;
            div_rem = sa % sb;
        end
    end

    always_comb begin
        alu = '0;
        case (opcode)
            OP_ADD:  alu = ZW'(sum_w);
            OP_SUB:  alu = ZW'(diff_w);
            OP_AND:  alu = ZW'(and_w);
            OP_OR:   alu = ZW'(or_w);
            OP_ROR:  alu = ZW'(ror_w);
            OP_ROL:  alu = ZW'(rol_full[ZW-1:WIDTH]);
            OP_SHR:  alu = ZW'(WIDTH'(bus >> sh));
            OP_SHRA: alu = ZW'(shra_w);
            OP_SHL:  alu = ZW'(WIDTH'(bus << sh));
            OP_DIV:  alu = {div_rem, div_quo};
            OP_MUL:  alu = prod_w;
            OP_NEG:  alu = ZW'(neg_w);
            OP_NOT:  alu = ZW'(not_w);
            default: alu = '0;
        endcase
    end

    // Next-state for every register; increment beats a bus load of PC
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        y_d   = y_q;
        z_d   = z_q;
        for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];

        if (IncPC)     pc_d = pc_q + WIDTH'(1);
        else if (PCin) pc_d = bus;
        if (IRin)  ir_d  = bus;
        if (MARin) mar_d = bus;
        if (MDRin) mdr_d = Read ? Mdatain : bus;
        if (HIin)  hi_d  = bus;
        if (LOin)  lo_d  = bus;
        if (Yin)   y_d   = bus;
        for (int i = 0; i < NREG; i++) begin
            if (r_in[i]) rf_d[i] = bus;
        end
        if (ZLowIn)  z_d[WIDTH-1:0]  = alu[WIDTH-1:0];
        if (ZHighIn) z_d[ZW-1:WIDTH] = alu[ZW-1:WIDTH];
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            y_q   <= y_d;
            z_q   <= z_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign BusMuxOut = bus;
    assign IRq       = ir_q;
    assign MARq      = mar_q;

    // HI/LO and the write-only registers have no reader inside this block
    assign unused_ok = ^{hi_q, lo_q, rf_q[1], rf_q[8], rf_q[9], rf_q[10], rf_q[11],
                         rf_q[12], rf_q[13], rf_q[14], rf_q[15], rol_full[WIDTH-1:0]};

endmodule

// File: tb/tb_data_path.sv
// Randomized bench for data_path: a behavioural model of the register set and ALU predicts
// the bus, IR and MAR every cycle; directed sequences pin the model with literal values.
module tb_data_path;

    logic        clock;
    logic        clear;
    logic        PCout, Zhighout, Zlowout, MDRout;
    logic        R0out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [4:0]  opcode;
    logic [15:0] rin;
    logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, IRq, MARq;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
    logic [31:0] m_r [16];
    logic [63:0] m_z;

    data_path #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R0out(R0out), .R2out(R2out), .R3out(R3out), .R4out(R4out),
        .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .opcode(opcode),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut), .IRq(IRq), .MARq(MARq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_bus();
        if (Zlowout)  return m_z[31:0];
        if (Zhighout) return m_z[63:32];
        if (MDRout)   return m_mdr;
        if (PCout)    return m_pc;
        if (R0out)    return m_r[0];
        if (R2out)    return m_r[2];
        if (R3out)    return m_r[3];
        if (R4out)    return m_r[4];
        if (R5out)    return m_r[5];
        if (R6out)    return m_r[6];
        if (R7out)    return m_r[7];
        return 32'h0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        int unsigned n;
        logic [31:0] r;
        longint sa, sb, q, rm, p;
        n  = int'(a[4:0]);
        r  = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'd3:  return {32'h0, a + b + {31'h0, cin}};
            5'd4:  return {32'h0, a - b - {31'h0, cin}};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  begin for (int i = 0; i < n; i++) r = {r[0], r[31:1]}; return {32'h0, r}; end
            5'd8:  begin for (int i = 0; i < n; i++) r = {r[30:0], r[31]}; return {32'h0, r}; end
            5'd9:  return {32'h0, b >> n};
            5'd10: begin for (int i = 0; i < n; i++) r = {r[31], r[31:1]}; return {32'h0, r}; end
            5'd11: return {32'h0, b << n};
            5'd15: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            5'd16: begin p = sa * sb; return p; end
            5'd17: return {32'h0, 32'h0 - b};
            5'd18: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_hi = 0; m_lo = 0; m_y = 0; m_z = 0;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
    endtask

    task automatic idle();
        PCout = 0; Zhighout = 0; Zlowout = 0; MDRout = 0;
        R0out = 0; R2out = 0; R3out = 0; R4out = 0; R5out = 0; R6out = 0; R7out = 0;
        MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
        opcode = 0; rin = 0; HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
        Mdatain = 0;
    endtask

    // Called between a falling edge and the next rising edge with inputs already applied
    task automatic tick();
        logic [31:0] bv;
        logic [63:0] av;
        #1;
        bv = m_bus();
        av = m_alu(opcode, m_y, bv, Cin);
        cmp("bus", BusMuxOut, bv);
        cmp("ir", IRq, m_ir);
        cmp("mar", MARq, m_mar);
        @(posedge clock);
        if (clear) begin
            if (IncPC)     m_pc = m_pc + 1;
            else if (PCin) m_pc = bv;
            if (IRin)  m_ir  = bv;
            if (MARin) m_mar = bv;
            if (MDRin) m_mdr = Read ? Mdatain : bv;
            if (Yin)   m_y   = bv;
            if (HIin)  m_hi  = bv;
            if (LOin)  m_lo  = bv;
            for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = bv;
            if (ZLowIn)  m_z[31:0]  = av[31:0];
            if (ZHighIn) m_z[63:32] = av[63:32];
        end
        @(negedge clock);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); Mdatain = v; Read = 1; MDRin = 1; tick(); idle();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        load_mdr(v); MDRout = 1; rin[idx] = 1; tick(); idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v); MDRout = 1; Yin = 1; tick(); idle();
    endtask

    task automatic peek(input string nm, input logic [31:0] exp);
        #1 cmp(nm, BusMuxOut, exp);
    endtask

    initial begin
        int ops[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
        idle();
        clear = 1;
        model_reset();
        #1 clear = 0;
        #2;
        cmp("rst_bus", BusMuxOut, 32'h0);
        cmp("rst_ir", IRq, 32'h0);
        cmp("rst_mar", MARq, 32'h0);
        @(negedge clock);
        tick(); tick();
        clear = 1;

        // load path
        idle(); Mdatain = 32'h12; Read = 1; MDRin = 1; tick();
        idle(); MDRout = 1; rin[4] = 1; peek("load_bus", 32'h12); tick();
        idle(); R4out = 1; peek("load_r4", 32'h12); tick(); idle();

        // PC increment into MAR, then wrap
        PCout = 1; MARin = 1; IncPC = 1; tick(); idle();
        #1 cmp("mar_pc0", MARq, 32'h0);
        PCout = 1; peek("pc_inc", 32'h1); tick(); idle();
        load_mdr(32'hFFFF_FFFF); MDRout = 1; PCin = 1; tick(); idle();
        PCout = 1; MARin = 1; IncPC = 1; tick(); idle();
        #1 cmp("mar_pcmax", MARq, 32'hFFFF_FFFF);
        PCout = 1; peek("pc_wrap", 32'h0); tick(); idle();

        // ROR R4,R3,R7
        load_reg(3, 32'h7F);
        load_reg(7, 32'h01);
        R7out = 1; Yin = 1; tick(); idle();
        R3out = 1; opcode = 5'b00111; ZLowIn = 1; tick(); idle();
        Zlowout = 1; rin[4] = 1; peek("ror_z", 32'h8000_003F); tick(); idle();
        R4out = 1; peek("ror_r4", 32'h8000_003F); tick(); idle();

        // MUL
        load_y(32'hFFFF_FFFE); load_mdr(32'd3);
        MDRout = 1; opcode = 5'b10000; ZHighIn = 1; ZLowIn = 1; tick(); idle();
        Zhighout = 1; peek("mul_hi", 32'hFFFF_FFFF); tick(); idle();
        Zlowout = 1; peek("mul_lo", 32'hFFFF_FFFA); tick(); idle();

        // DIV, then divide by zero
        load_y(32'd17); load_mdr(32'd5);
        MDRout = 1; opcode = 5'b01111; ZHighIn = 1; ZLowIn = 1; tick(); idle();
        Zlowout = 1; peek("div_lo", 32'd3); tick(); idle();
        Zhighout = 1; HIin = 1; peek("div_hi", 32'd2); tick(); idle();
        load_mdr(32'd0);
        MDRout = 1; opcode = 5'b01111; ZHighIn = 1; ZLowIn = 1; tick(); idle();
        Zlowout = 1; peek("div0_lo", 32'hFFFF_FFFF); tick(); idle();
        Zhighout = 1; peek("div0_hi", 32'd17); tick(); idle();

        // bus priority and idle
        peek("bus_idle", 32'h0);
        load_y(32'd2); load_mdr(32'd3);
        MDRout = 1; opcode = 5'b00011; ZLowIn = 1; tick(); idle();
        load_reg(3, 32'd9);
        Zlowout = 1; R3out = 1; peek("bus_prio", 32'd5); tick(); idle();

        // asynchronous clear mid-operation
        #2 clear = 0; model_reset();
        R4out = 1; peek("clr_r4", 32'h0); R4out = 0;
        Zlowout = 1; peek("clr_zlo", 32'h0); Zlowout = 0;
        Mdatain = 32'h55; Read = 1; MDRin = 1; tick(); idle();
        MDRout = 1; peek("clr_mdr", 32'h0); idle();
        clear = 1;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            Zlowout  = ($urandom_range(0, 5) == 0); Zhighout = ($urandom_range(0, 5) == 0);
            MDRout   = ($urandom_range(0, 5) == 0); PCout    = ($urandom_range(0, 5) == 0);
            R0out    = ($urandom_range(0, 5) == 0); R2out    = ($urandom_range(0, 5) == 0);
            R3out    = ($urandom_range(0, 5) == 0); R4out    = ($urandom_range(0, 5) == 0);
            R5out    = ($urandom_range(0, 5) == 0); R6out    = ($urandom_range(0, 5) == 0);
            R7out    = ($urandom_range(0, 5) == 0);
            MARin = ($urandom_range(0, 3) == 0); PCin = ($urandom_range(0, 3) == 0);
            MDRin = ($urandom_range(0, 2) == 0); IRin = ($urandom_range(0, 3) == 0);
            Yin   = ($urandom_range(0, 3) == 0); IncPC = ($urandom_range(0, 7) == 0);
            HIin  = ($urandom_range(0, 3) == 0); LOin = ($urandom_range(0, 3) == 0);
            ZLowIn = ($urandom_range(0, 2) == 0); ZHighIn = ($urandom_range(0, 2) == 0);
            Read = 1'($urandom_range(0, 1)); Cin = 1'($urandom_range(0, 1));
            rin = 16'($urandom);
            opcode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'(ops[$urandom_range(0, 12)]);
            Mdatain = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 199) == 0) begin
                clear = 0;
                model_reset();
                tick();
                clear = 1;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus datapath for the teaching RISC CPU.
- Contains PC, IR, MAR, MDR, register file R0–R15, HI/LO, ALU operand latch Y and 64-bit result register Z.
- Every transfer goes over one shared bus, driven by one-hot "out" strobes; a source is captured by "in" strobes on the rising clock edge.
- The control unit or testbench sequences the strobes; this block has no internal FSM.

Parameters:
WIDTH, 32, datapath/bus width (all registers; Z is 2*WIDTH)

Ports:
clock  in  1  system clock, rising-edge active
clear  in  1  reset, asynchronous, active-low
PCout, Zhighout, Zlowout, MDRout  in  1 each  bus drive strobes for PC, Z[63:32], Z[31:0], MDR
R0out, R2out, R3out, R4out, R5out, R6out, R7out  in  1 each  bus drive strobes for those registers
MARin, PCin, MDRin, IRin, Yin  in  1 each  load enables from bus (MDRin: see Read)
IncPC  in  1  PC increment enable
Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
opcode  in  5  ALU operation select
R0in … R15in  in  1 each  register-file load enables
HIin, LOin  in  1 each  HI/LO load enables from bus
ZHighIn, ZLowIn  in  1 each  load ALU result[63:32] into Z high and ALU result[31:0] into Z low
Cin  in  1  carry-in for ADD/SUB
Mdatain  in  32  memory read data
BusMuxOut  out  32  current bus value (observation)
IRq  out  32  IR contents
MARq  out  32  MAR contents (memory address)

Behaviour:
- Reset
  - clear low, asynchronously and independent of clock: every register becomes 0 (PC, IR, MAR, MDR, R0–R15, HI, LO, Y, Z).
  - Outputs follow, so BusMuxOut = 0 while no strobe is active.
- Bus
  - Purely combinational mux.
  - Priority when several strobes are high: Zlowout > Zhighout > MDRout > PCout > R0out > R2out > R3out > R4out > R5out > R6out > R7out.
  - No strobe active: bus = 0.
  - R1 and R8–R15 are write-only from the bus in this block.
- Register loads
  - On posedge clock, each register whose enable is high captures the bus.
  - MDR: with MDRin=1, captures Mdatain if Read=1, otherwise the bus.
  - Loads take effect the same edge; the new value is visible on the bus from the next cycle.
- PC
  - IncPC=1 at an edge: PC <= PC+1, wrapping at 0xFFFFFFFF to 0.
  - IncPC has priority over PCin.
- ALU (combinational)
  - Operands: A = Y, B = bus.
  - Result is 64 bits. Single-word operations zero-fill bits 63:32.
  - Shift/rotate: value = B, amount = A[4:0].
- Opcodes
  - 00011 ADD A+B+Cin
  - 00100 SUB A−B−Cin
  - 00101 AND
  - 00110 OR
  - 00111 ROR B rotated right by A[4:0]
  - 01000 ROL
  - 01001 SHR logical
  - 01010 SHRA arithmetic
  - 01011 SHL
  - 01111 DIV signed: low = A/B truncated toward zero, high = A%B (sign follows A). B=0 gives low = 0xFFFFFFFF, high = A.
  - 10000 MUL signed 32x32 → 64
  - 10001 NEG −B
  - 10010 NOT ~B
  - All other codes: result 0.
- Z
  - ZLowIn loads result[31:0]; ZHighIn loads result[63:32].
  - Both may be asserted in the same cycle.
  - Z holds its value otherwise.
- Simultaneous events
  - The same register enabled while also driving the bus loads its own value (no change).
  - clear overrides all enables.

Test Plan:
- Load path: Mdatain=0x12, Read=1+MDRin=1 for one edge → MDR=0x12; then MDRout=1+R4in=1 → R4=0x12, BusMuxOut=0x12 during that cycle.
- ROR R4,R3,R7: R3=0x7F, R7=0x01; R7out+Yin → Y=1; R3out, opcode=00111, ZLowIn → Z[31:0]=0x8000003F; Zlowout+R4in → R4=0x8000003F.
- PC/MAR: PC=0, PCout+MARin+IncPC for one edge → MARq=0, PC=1; repeat from PC=0xFFFFFFFF → PC=0.
- MUL/DIV:
  - Y=0xFFFFFFFE, bus=3, opcode 10000, ZHighIn+ZLowIn → Z=0xFFFFFFFF_FFFFFFFA.
  - Y=17, bus=5, opcode 01111 → Z low=3, Z high=2; Zhighout+HIin → HI=2.
  - Y=17, bus=0 → low=0xFFFFFFFF, high=17.
- Reset mid-operation: R4=0x8000003F, Z nonzero, pull clear low between edges → all registers 0 immediately; MDRin/Read held high during clear → MDR stays 0.
- Bus priority/idle: no strobes → BusMuxOut=0; Zlowout and R3out both high with Z low=5, R3=9 → BusMuxOut=5.
